// File: rtl/pcs25g_pkg.sv
// Shared definitions for the 25G PCS receive lane: sync-header codes, block geometry
// and the block-lock state encoding.
package pcs25g_pkg;
  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int BLOCK_W         = 66;
  localparam int PAYLOAD_W       = 64;
  localparam int BLOCKS_PER_LANE = 4;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_SLIP   = 2'd2,
    ST_WAIT   = 2'd3
  } bs_state_e;

  function automatic logic sh_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction
endpackage

// File: rtl/sh_check_4.sv
// Classifies the four sync headers of one beat: per-block valid flags and the
// number of invalid headers.
module sh_check_4
  import pcs25g_pkg::*;
(
  input  logic [7:0] i_hdr,
  output logic [3:0] o_hdr_ok,
  output logic [2:0] o_nbad
);
  for (genvar g = 0; g < BLOCKS_PER_LANE; g++) begin : g_hdr
    assign o_hdr_ok[g] = sh_valid(i_hdr[2*g +: 2]);
  end

  always_comb begin
    o_nbad = '0;
    for (int i = 0; i < BLOCKS_PER_LANE; i++)
      o_nbad = o_nbad + {2'b00, ~o_hdr_ok[i]};
  end
endmodule

// File: rtl/perlane_blocksync.sv
// Per-lane 64b/66b block synchroniser: header check, block-lock FSM with gearbox
// slip requests, header stripping towards the descrambler.
module perlane_blocksync
  import pcs25g_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int INVLD_MAX = 16,
  parameter int SLIP_WAIT = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_enable,
  input  logic [263:0] in_rxdata,
  input  logic         in_rxdata_valid,
  output logic [255:0] out_rxdata,
  output logic [7:0]   out_rxhdr,
  output logic         out_rxdata_valid,
  output logic         out_rxdata_error,
  output logic         out_block_lock,
  output logic         out_slip
);
  localparam int WAIT_W = (SLIP_WAIT < 2) ? 1 : $clog2(SLIP_WAIT + 1);

  bs_state_e         r_state, w_state_nxt;
  logic [6:0]        r_sh_cnt, w_sh_nxt;
  logic [4:0]        r_bad_cnt, w_bad_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;

  logic [255:0] r_data;
  logic [7:0]   r_hdr;
  logic         r_valid, r_err, r_lock, r_slip;

  logic         w_beat;
  logic [7:0]   w_hdr;
  logic [255:0] w_payload;
  logic [3:0]   w_hdr_ok;
  logic [2:0]   w_nbad;
  logic [7:0]   w_sh_inc;
  logic [5:0]   w_bad_inc;

  assign w_beat = in_enable && in_rxdata_valid;

  for (genvar g = 0; g < BLOCKS_PER_LANE; g++) begin : g_blk
    assign w_hdr[2*g +: 2]                 = in_rxdata[BLOCK_W*g +: 2];
    assign w_payload[PAYLOAD_W*g +: PAYLOAD_W] = in_rxdata[BLOCK_W*g+2 +: PAYLOAD_W];
  end

  sh_check_4 u_sh_check (
    .i_hdr    (w_hdr),
    .o_hdr_ok (w_hdr_ok),
    .o_nbad   (w_nbad)
  );

  // One extra bit on the post-increment sums so the threshold compares cannot wrap.
  assign w_sh_inc  = {1'b0, r_sh_cnt} + 8'd4;
  assign w_bad_inc = {1'b0, r_bad_cnt} + {3'b000, w_nbad};

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      ST_HUNT: if (w_beat) begin
        if (w_nbad != 3'd0) begin
          w_state_nxt = ST_SLIP;
          w_sh_nxt    = '0;
          w_bad_nxt   = '0;
        end else if (w_sh_inc >= 8'(LOCK_CNT)) begin
          w_state_nxt = ST_LOCKED;
          w_sh_nxt    = '0;
          w_bad_nxt   = '0;
        end else begin
          w_sh_nxt = w_sh_inc[6:0];
        end
      end
      ST_LOCKED: if (w_beat) begin
        // Loss of lock takes priority over a window restart on the same beat.
        if (w_bad_inc >= 6'(INVLD_MAX)) begin
          w_state_nxt = ST_SLIP;
          w_sh_nxt    = '0;
          w_bad_nxt   = '0;
        end else if (w_sh_inc >= 8'(LOCK_CNT)) begin
          w_sh_nxt  = '0;
          w_bad_nxt = '0;
        end else begin
          w_sh_nxt  = w_sh_inc[6:0];
          w_bad_nxt = w_bad_inc[4:0];
        end
      end
      // Slip is a single-cycle state regardless of enable/valid.
      ST_SLIP: begin
        w_state_nxt = ST_WAIT;
        w_wait_nxt  = WAIT_W'(SLIP_WAIT);
      end
      ST_WAIT: if (w_beat) begin
        if (r_wait_cnt <= WAIT_W'(1)) begin
          w_state_nxt = ST_HUNT;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait_cnt - WAIT_W'(1);
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_HUNT;
      r_sh_cnt   <= '0;
      r_bad_cnt  <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sh_cnt   <= w_sh_nxt;
      r_bad_cnt  <= w_bad_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_hdr   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_lock  <= 1'b0;
      r_slip  <= 1'b0;
    end else begin
      if (w_beat) begin
        r_data <= w_payload;
        r_hdr  <= w_hdr;
      end
      r_valid <= w_beat && (r_state == ST_LOCKED);
      r_err   <= w_beat && (r_state == ST_LOCKED) && !(&w_hdr_ok);
      r_lock  <= (w_state_nxt == ST_LOCKED);
      r_slip  <= (w_state_nxt == ST_SLIP);
    end
  end

  assign out_rxdata       = r_data;
  assign out_rxhdr        = r_hdr;
  assign out_rxdata_valid = r_valid;
  assign out_rxdata_error = r_err;
  assign out_block_lock   = r_lock;
  assign out_slip         = r_slip;
endmodule

// File: tb/tb_perlane_blocksync.sv
// Scoreboard bench for perlane_blocksync: a driver feeds beats and a lock model,
// a negedge monitor compares every DUT output against the model's expectations.
module tb_perlane_blocksync;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_enable = 1'b0;
  logic         in_rxdata_valid = 1'b0;
  logic [263:0] in_rxdata = '0;
  logic [255:0] out_rxdata;
  logic [7:0]   out_rxhdr;
  logic         out_rxdata_valid, out_rxdata_error, out_block_lock, out_slip;

  always #5 clk = ~clk;

  perlane_blocksync dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_enable        (in_enable),
    .in_rxdata        (in_rxdata),
    .in_rxdata_valid  (in_rxdata_valid),
    .out_rxdata       (out_rxdata),
    .out_rxhdr        (out_rxhdr),
    .out_rxdata_valid (out_rxdata_valid),
    .out_rxdata_error (out_rxdata_error),
    .out_block_lock   (out_block_lock),
    .out_slip         (out_slip)
  );

  typedef struct { logic [255:0] d; logic [7:0] h; logic e; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  typedef enum { M_HUNT, M_LOCK, M_SLIP, M_WAIT } mode_e;
  mode_e m_mode = M_HUNT;
  int m_hdrs = 0, m_bad = 0, m_wait = 0;

  logic         exp_lock = 1'b0, exp_slip = 1'b0, exp_vld = 1'b0;
  logic [255:0] exp_data = '0;
  logic [7:0]   exp_hdr = '0;
  int n_slip_exp = 0, n_slip_seen = 0;
  bit mon_en = 1'b0;
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Build a beat from independent header/payload lists; badm marks blocks with an invalid header.
  function automatic void mk(input logic [3:0] badm, output logic [263:0] d,
                             output logic [255:0] pd, output logic [7:0] hd, output int nb);
    logic [63:0] p;
    logic [1:0]  h;
    nb = 0;
    d  = '0;
    pd = '0;
    hd = '0;
    for (int i = 0; i < 4; i++) begin
      p = {$urandom, $urandom};
      if (badm[i]) h = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      else         h = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      d[66*i +: 66] = {p, h};
      pd[64*i +: 64] = p;
      hd[2*i +: 2]   = h;
      nb += int'(badm[i]);
    end
  endfunction

  task automatic cyc(input logic en, input logic vld, input logic [3:0] badm);
    logic [263:0] d;
    logic [255:0] pd;
    logic [7:0]   hd;
    int nb;
    bit push, counted;
    mk(badm, d, pd, hd, nb);
    in_enable       = en;
    in_rxdata_valid = vld;
    in_rxdata       = d;
    counted = en && vld;
    push = 1'b0;
    if (m_mode == M_SLIP) begin
      m_mode = M_WAIT;
      m_wait = 8;
    end else if (counted) begin
      case (m_mode)
        M_HUNT: begin
          if (nb > 0) begin
            m_mode = M_SLIP; m_hdrs = 0; m_bad = 0;
          end else begin
            m_hdrs += 4;
            if (m_hdrs >= 64) begin m_mode = M_LOCK; m_hdrs = 0; end
          end
        end
        M_LOCK: begin
          push = 1'b1;
          m_hdrs += 4;
          m_bad  += nb;
          if (m_bad >= 16) begin m_mode = M_SLIP; m_hdrs = 0; m_bad = 0; end
          else if (m_hdrs >= 64) begin m_hdrs = 0; m_bad = 0; end
        end
        M_WAIT: begin
          m_wait--;
          if (m_wait == 0) m_mode = M_HUNT;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    exp_vld = push;
    if (push) sb_q.push_back('{pd, hd, (nb > 0)});
    if (counted) begin exp_data = pd; exp_hdr = hd; end
    exp_lock = (m_mode == M_LOCK);
    exp_slip = (m_mode == M_SLIP);
    if (exp_slip) n_slip_exp++;
    #1;
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    in_enable       = 1'b1;
    in_rxdata_valid = 1'b1;
    in_rxdata       = {264{1'b1}};
    m_mode = M_HUNT; m_hdrs = 0; m_bad = 0; m_wait = 0;
    @(posedge clk);
    exp_vld = 1'b0; exp_lock = 1'b0; exp_slip = 1'b0;
    exp_data = '0; exp_hdr = '0;
    sb_q.delete();
    #1;
    chk("rst_data",  out_rxdata, 0);
    chk("rst_hdr",   out_rxhdr, 0);
    chk("rst_valid", out_rxdata_valid, 0);
    chk("rst_error", out_rxdata_error, 0);
    chk("rst_lock",  out_block_lock, 0);
    chk("rst_slip",  out_slip, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_lock",  out_block_lock, exp_lock);
      chk("mon_slip",  out_slip, exp_slip);
      chk("mon_valid", out_rxdata_valid, exp_vld);
      chk("mon_hold_data", out_rxdata, exp_data);
      chk("mon_hold_hdr",  out_rxhdr, exp_hdr);
      if (out_slip) n_slip_seen++;
      if (exp_vld) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow: got empty queue want entry");
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_data",  out_rxdata, mon_e.d);
          chk("sb_hdr",   out_rxhdr, mon_e.h);
          chk("sb_error", out_rxdata_error, mon_e.e);
        end
      end else begin
        chk("idle_error", out_rxdata_error, 0);
      end
    end
  end

  initial begin
    logic [3:0] m;
    do_reset();

    // Clean hunt to lock, then locked traffic
    repeat (15) cyc(1, 1, 4'h0);
    chk("t1_not_yet", out_block_lock, 0);
    cyc(1, 1, 4'h0);
    chk("t1_lock", out_block_lock, 1);
    repeat (4) cyc(1, 1, 4'h0);

    // Bad header while hunting -> slip, wait, re-hunt
    do_reset();
    repeat (3) cyc(1, 1, 4'h0);
    cyc(1, 1, 4'b0100);
    chk("t2_slip_hi", out_slip, 1);
    cyc(1, 1, 4'h0);
    chk("t2_slip_lo", out_slip, 0);
    repeat (8) cyc(1, 1, 4'hf);
    repeat (15) cyc(1, 1, 4'h0);
    chk("t2_not_yet", out_block_lock, 0);
    cyc(1, 1, 4'h0);
    chk("t2_lock", out_block_lock, 1);

    // Four all-bad beats while locked -> delivered with error, then loss of lock
    repeat (3) cyc(1, 1, 4'hf);
    chk("t3_still_locked", out_block_lock, 1);
    cyc(1, 1, 4'hf);
    chk("t3_lost", out_block_lock, 0);
    chk("t3_slip", out_slip, 1);
    repeat (9) cyc(1, 1, 4'h0);
    repeat (16) cyc(1, 1, 4'h0);
    chk("t3_relock", out_block_lock, 1);

    // 15 bad per window survives; 16 in a window drops lock
    repeat (2) begin
      for (int b = 0; b < 16; b++) begin
        m = (b < 15) ? 4'(1 << (b % 4)) : 4'h0;
        cyc(1, 1, m);
      end
    end
    chk("t4_held", out_block_lock, 1);
    for (int b = 0; b < 16; b++) cyc(1, 1, 4'(1 << (b % 4)));
    chk("t4_lost", out_block_lock, 0);
    // Slip pulse still completes with enable low
    cyc(0, 1, 4'h0);
    repeat (12) cyc(1, 1'($urandom_range(0, 1)), 4'h0);

    // Random gaps and sparse errors
    repeat (30) cyc(1, 1, 4'h0);
    chk("t5_lock", out_block_lock, 1);
    repeat (250) begin
      m = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), m);
    end

    // Reset during WAIT, then clean hunt from zero
    do_reset();
    repeat (5) cyc(1, 1, 4'h0);
    cyc(1, 1, 4'b1000);
    repeat (4) cyc(1, 1, 4'h0);
    do_reset();
    repeat (15) cyc(1, 1, 4'h0);
    chk("t6_not_yet", out_block_lock, 0);
    cyc(1, 1, 4'h0);
    chk("t6_lock", out_block_lock, 1);

    // Reset in the slip cycle itself
    do_reset();
    cyc(1, 1, 4'b0010);
    chk("t7_slip_hi", out_slip, 1);
    do_reset();
    repeat (16) cyc(1, 1, 4'h0);
    chk("t7_lock", out_block_lock, 1);

    repeat (3) cyc(0, 0, 4'h0);
    chk("sb_empty", sb_q.size(), 0);
    chk("slip_count", n_slip_seen, n_slip_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
